// File: rtl/rs_pkg.sv
// Shared reservation-station types and default sizing, also used by the EX and ROB blocks.
package rs_pkg;

  localparam int RS_DEPTH  = 4;
  localparam int ROB_TAG_W = 4;
  localparam int DATA_W    = 32;
  localparam int OP_W      = 6;

  typedef struct packed {
    logic                 valid;
    logic [OP_W-1:0]      op;
    logic [ROB_TAG_W-1:0] dst;
    logic                 s1_rdy;
    logic [ROB_TAG_W-1:0] s1_tag;
    logic [DATA_W-1:0]    s1_val;
    logic                 s2_rdy;
    logic [ROB_TAG_W-1:0] s2_tag;
    logic [DATA_W-1:0]    s2_val;
  } rs_entry_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Find-first-set: returns the lowest set index of req and whether any bit is set.
module rs_prio_enc
  import rs_pkg::*;
#(
  parameter int N = RS_DEPTH
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int W = $clog2(N);

  always_comb begin
    idx   = '0;
    found = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/rs_snoop_station.sv
// Reservation station: holds dispatched ops, snoops the ROB broadcast bus to wake
// operands, and issues the lowest-index operand-complete op to EX.
module rs_snoop_station
  import rs_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = rs_pkg::DATA_W,
  parameter int OP_W   = rs_pkg::OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [TAG_W-1:0]         disp_dst,
  input  logic                     disp_s1_rdy,
  input  logic [TAG_W-1:0]         disp_s1_tag,
  input  logic [DATA_W-1:0]        disp_s1_val,
  input  logic                     disp_s2_rdy,
  input  logic [TAG_W-1:0]         disp_s2_tag,
  input  logic [DATA_W-1:0]        disp_s2_val,
  input  logic                     bc_valid,
  input  logic [TAG_W-1:0]         bc_tag,
  input  logic [DATA_W-1:0]        bc_data,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [TAG_W-1:0]         iss_dst,
  output logic [DATA_W-1:0]        iss_v1,
  output logic [DATA_W-1:0]        iss_v2,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dst;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_val;
    logic              s2_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_val;
  } entry_t;

  entry_t           slots [DEPTH];
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] rdy_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] rdy_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] held_idx;
  logic             free_found;
  logic             rdy_found;
  logic             sel_found;
  logic             use_held;
  logic             held;
  logic             disp_fire;
  logic             iss_fire;
  logic             byp_s1;
  logic             byp_s2;

  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = ~slots[i].valid;
      rdy_vec[i]  = slots[i].valid & slots[i].s1_rdy & slots[i].s2_rdy;
    end
  end

  rs_prio_enc #(.N(DEPTH)) u_free_sel (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_prio_enc #(.N(DEPTH)) u_rdy_sel (
    .req   (rdy_vec),
    .idx   (rdy_idx),
    .found (rdy_found)
  );

  // An offer refused by EX stays locked to its slot so the outputs do not jump
  // to a lower-index entry that wakes or is dispatched while EX is stalled.
  always_comb begin
    use_held  = held & rdy_vec[held_idx];
    sel_idx   = use_held ? held_idx : rdy_idx;
    sel_found = use_held | rdy_found;
  end

  assign disp_ready = (occupancy < FULL) & ~flush;
  assign iss_valid  = sel_found & ~flush;
  assign disp_fire  = disp_valid & disp_ready & free_found;
  assign iss_fire   = iss_valid & iss_ready;

  assign byp_s1 = bc_valid & ~disp_s1_rdy & (disp_s1_tag == bc_tag);
  assign byp_s2 = bc_valid & ~disp_s2_rdy & (disp_s2_tag == bc_tag);

  always_comb begin
    iss_op  = '0;
    iss_dst = '0;
    iss_v1  = '0;
    iss_v2  = '0;
    if (iss_valid) begin
      iss_op  = slots[sel_idx].op;
      iss_dst = slots[sel_idx].dst;
      iss_v1  = slots[sel_idx].s1_val;
      iss_v2  = slots[sel_idx].s2_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      occupancy <= '0;
      held      <= 1'b0;
      held_idx  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i].valid <= 1'b0;
      occupancy <= '0;
      held      <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slots[i].valid && !slots[i].s1_rdy && bc_valid && slots[i].s1_tag == bc_tag) begin
          slots[i].s1_rdy <= 1'b1;
          slots[i].s1_val <= bc_data;
        end
        if (slots[i].valid && !slots[i].s2_rdy && bc_valid && slots[i].s2_tag == bc_tag) begin
          slots[i].s2_rdy <= 1'b1;
          slots[i].s2_val <= bc_data;
        end
        if (iss_fire && sel_idx == IDX_W'(i)) slots[i].valid <= 1'b0;
        // The free slot is never the issuing one, so these writes never collide.
        if (disp_fire && free_idx == IDX_W'(i)) begin
          slots[i] <= '{valid:  1'b1,
                        op:     disp_op,
                        dst:    disp_dst,
                        s1_rdy: disp_s1_rdy | byp_s1,
                        s1_tag: disp_s1_tag,
                        s1_val: byp_s1 ? bc_data : disp_s1_val,
                        s2_rdy: disp_s2_rdy | byp_s2,
                        s2_tag: disp_s2_tag,
                        s2_val: byp_s2 ? bc_data : disp_s2_val};
        end
      end
      occupancy <= occupancy + OCC_W'(disp_fire) - OCC_W'(iss_fire);
      held      <= iss_valid & ~iss_ready;
      held_idx  <= sel_idx;
    end
  end

endmodule
